// File: rtl/blk_80cd51_pkg.sv
// Shared types and constants for the gated N-input BIST clock selector.
//   clk_sel_state_e : switch-over FSM state (3-bit encoding)
//   clk_sel_cnt_w   : wait-counter width for a given pair of wait lengths
//   CLK_SEL_*       : default wait lengths, counter width and request-to-done latency
package memlibc_clk_sel_pkg;

    typedef enum logic [2:0] {
        CS_IDLE     = 3'd0,
        CS_GATE_OFF = 3'd1,
        CS_SWITCH   = 3'd2,
        CS_SETTLE   = 3'd3,
        CS_DONE     = 3'd4
    } clk_sel_state_e;

    // Counter must hold the larger of the two reload values.
    function automatic int unsigned clk_sel_cnt_w(input int unsigned gate_off,
                                                  input int unsigned settle);
        int unsigned m;
        m = (gate_off > settle) ? gate_off : settle;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned CLK_SEL_GATE_OFF_DEF = 4;
    localparam int unsigned CLK_SEL_SETTLE_DEF   = 4;
    localparam int unsigned CLK_SEL_CNT_W        = clk_sel_cnt_w(CLK_SEL_GATE_OFF_DEF,
                                                                 CLK_SEL_SETTLE_DEF);
    localparam int unsigned CLK_SEL_LATENCY      = CLK_SEL_GATE_OFF_DEF + CLK_SEL_SETTLE_DEF + 2;

endpackage

// File: rtl/blk_80cd51_if.sv
// Switch-request handshake between a requester (master) and the clock selector (slave).
//   req_valid : request valid
//   req_sel   : requested clock index
//   req_ready : selector can take a request this cycle
interface blk_80cd51_if #(
    parameter int unsigned SEL_W = 2
);
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;

    modport master (output req_valid, output req_sel, input req_ready);
    modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/blk_80cd51_muxn.sv
// N:1 clock mux as a balanced binary tree of 2:1 clock-mux cells.
//   clk_in  : candidate clocks
//   sel     : index of the clock to pass
//   clk_out : clk_in[sel]; leaves beyond NUM_INPUTS are tied low

// Leaf 2:1 clock-mux cell.
module memlibc_clk_mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module memlibc_memory_bist_assembly_rtl_tessent_clk_muxn #(
    parameter  int unsigned NUM_INPUTS = 4,
    localparam int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] clk_in,
    input  logic [SEL_W-1:0]      sel,
    output logic                  clk_out
);
    localparam int unsigned LEAVES = 1 << SEL_W;

    // Level 0 is the root; level SEL_W holds the (padded) leaves. The root uses the select MSB.
    for (genvar d = 0; d <= SEL_W; d++) begin : g_lvl
        logic [(1<<d)-1:0] node;
        if (d == SEL_W) begin : g_leaf
            for (genvar p = 0; p < LEAVES; p++) begin : g_p
                if (p < NUM_INPUTS) begin : g_used
                    assign node[p] = clk_in[p];
                end else begin : g_tie
                    assign node[p] = 1'b0;
                end
            end
        end else begin : g_mux
            for (genvar p = 0; p < (1 << d); p++) begin : g_p
                memlibc_clk_mux2 u_mux2 (
                    .a (g_lvl[d+1].node[2*p]),
                    .b (g_lvl[d+1].node[2*p+1]),
                    .s (sel[SEL_W-1-d]),
                    .y (node[p])
                );
            end
        end
    end

    assign clk_out = g_lvl[0].node[0];
endmodule

// File: rtl/blk_80cd51.sv
// BIST clock selector with a sequenced, gated switch-over: gate off, wait, switch, settle, re-enable.
//   clk, reset : control clock, async active-high reset
//   clk_in     : candidate clocks
//   req        : switch request handshake (slave side)
//   sel_out    : current select (registered)
//   clk_en     : enable for the downstream clock gate (registered)
//   clk_out    : clk_in[sel_out] through the mux tree
//   busy       : switch in progress
//   done, err  : one-cycle completion / illegal-index pulses
module blk_80cd51
    import memlibc_clk_sel_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS      = 4,
    parameter  int unsigned GATE_OFF_CYCLES = 4,
    parameter  int unsigned SETTLE_CYCLES   = 4,
    parameter  int unsigned RESET_SEL       = 0,
    localparam int unsigned SEL_W           = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] clk_in,
    blk_80cd51_if.slave           req,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  clk_en,
    output logic                  clk_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned CNT_W = clk_sel_cnt_w(GATE_OFF_CYCLES, SETTLE_CYCLES);

    if (NUM_INPUTS < 2 || GATE_OFF_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        RESET_SEL >= NUM_INPUTS) begin : g_bad_param
        $fatal(1, "blk_80cd51: parameter out of range");
    end

    clk_sel_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] target;

    assign req.req_ready = (state == CS_IDLE);
    assign busy          = (state != CS_IDLE);

    // Switch-over sequencer; sel_out only moves in SWITCH, where clk_en is already low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CS_IDLE;
            cnt     <= '0;
            target  <= '0;
            sel_out <= SEL_W'(RESET_SEL);
            clk_en  <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                CS_IDLE: begin
                    if (req.req_valid) begin
                        if (32'(req.req_sel) >= NUM_INPUTS) begin
                            err <= 1'b1;
                        end else if (req.req_sel == sel_out) begin
                            target <= req.req_sel;
                            done   <= 1'b1;
                            state  <= CS_DONE;
                        end else begin
                            target <= req.req_sel;
                            cnt    <= CNT_W'(GATE_OFF_CYCLES - 1);
                            clk_en <= 1'b0;
                            state  <= CS_GATE_OFF;
                        end
                    end
                end
                CS_GATE_OFF: begin
                    if (cnt == '0) state <= CS_SWITCH;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                CS_SWITCH: begin
                    sel_out <= target;
                    cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                    state   <= CS_SETTLE;
                end
                CS_SETTLE: begin
                    if (cnt == '0) begin
                        clk_en <= 1'b1;
                        done   <= 1'b1;
                        state  <= CS_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CS_DONE: state <= CS_IDLE;
                default: state <= CS_IDLE;
            endcase
        end
    end

    memlibc_memory_bist_assembly_rtl_tessent_clk_muxn #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_muxn (
        .clk_in  (clk_in),
        .sel     (sel_out),
        .clk_out (clk_out)
    );
endmodule

// File: tb/tb_blk_80cd51.sv
// Self-checking bench for blk_80cd51: a 4-input and a 3-input instance, scoreboard of expected completions.
module tb_blk_80cd51;

    typedef struct {
        bit         is_err;
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ck0 = 1'b0, ck1 = 1'b0, ck2 = 1'b0, ck3 = 1'b0;
    logic [3:0] clk_in4;
    logic [2:0] clk_in3;

    logic [1:0] sel_out4, sel_out3;
    logic       clk_en4, clk_out4, busy4, done4, err4;
    logic       clk_en3, clk_out3, busy3, done3, err3;

    blk_80cd51_if #(.SEL_W(2)) req4 ();
    blk_80cd51_if #(.SEL_W(2)) req3 ();

    assign clk_in4 = {ck3, ck2, ck1, ck0};
    assign clk_in3 = {ck2, ck1, ck0};

    // clk edges land on multiples of 20, candidate-clock edges on even times; sampling uses odd times.
    always #20 clk = ~clk;
    initial begin #2; forever #4  ck0 = ~ck0; end
    initial begin #2; forever #6  ck1 = ~ck1; end
    initial begin #2; forever #8  ck2 = ~ck2; end
    initial begin #2; forever #10 ck3 = ~ck3; end

    blk_80cd51 dut4 (
        .clk     (clk),
        .reset   (reset),
        .clk_in  (clk_in4),
        .req     (req4),
        .sel_out (sel_out4),
        .clk_en  (clk_en4),
        .clk_out (clk_out4),
        .busy    (busy4),
        .done    (done4),
        .err     (err4)
    );

    blk_80cd51 #(.NUM_INPUTS(3)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .clk_in  (clk_in3),
        .req     (req3),
        .sel_out (sel_out3),
        .clk_en  (clk_en3),
        .clk_out (clk_out3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        apply_reset();
        n_total++; if (sel_out4 !== 2'd0) $display("FAIL reset_sel_out got=%0d exp=0", sel_out4); else n_pass++;
        n_total++; if (clk_en4 !== 1'b1) $display("FAIL reset_clk_en got=%b exp=1", clk_en4); else n_pass++;
        n_total++; if (req4.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req4.req_ready); else n_pass++;
        n_total++; if (busy4 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy4); else n_pass++;
        n_total++; if (done4 !== 1'b0 || err4 !== 1'b0) $display("FAIL reset_done_err got=%b%b exp=00", done4, err4); else n_pass++;
        n_total++; if (sel_out3 !== 2'd0 || clk_en3 !== 1'b1 || busy3 !== 1'b0) $display("FAIL reset_dut3 got sel=%0d en=%b busy=%b exp sel=0 en=1 busy=0", sel_out3, clk_en3, busy3); else n_pass++;
        bad = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (clk_out4 !== ck0 || clk_out3 !== ck0) bad++;
            #2;
        end
        n_total++; if (bad != 0) $display("FAIL reset_clk_out_follow got=%0d mismatching samples exp=0", bad); else n_pass++;
    endtask

    task automatic test_switch();
        exp_t e;
        bit   got;
        int   bad;
        @(negedge clk);
        req4.req_valid = 1'b1;
        req4.req_sel   = 2'd2;
        sb.push_back('{1'b0, 2'd2, 10});
        got = 1'b0;
        for (int c = 1; c <= 14 && !got; c++) begin
            @(negedge clk);
            if (c == 1) req4.req_valid = 1'b0;
            if (c <= 10) begin
                n_total++; if (clk_en4 !== 1'(c == 10)) $display("FAIL switch_clk_en cyc=%0d got=%b exp=%b", c, clk_en4, (c == 10)); else n_pass++;
                n_total++; if (sel_out4 !== ((c >= 6) ? 2'd2 : 2'd0)) $display("FAIL switch_sel_out cyc=%0d got=%0d exp=%0d", c, sel_out4, (c >= 6) ? 2 : 0); else n_pass++;
            end
            if (done4 || err4) begin
                got = 1'b1;
                e = sb.pop_front();
                n_total++; if (c != e.cyc || err4 !== e.is_err || sel_out4 !== e.sel) $display("FAIL switch_done got cyc=%0d err=%b sel=%0d exp cyc=%0d err=%b sel=%0d", c, err4, sel_out4, e.cyc, e.is_err, e.sel); else n_pass++;
            end
        end
        if (!got) begin
            n_total++; $display("FAIL switch_timeout got=no done exp=done at cycle 10");
            sb.delete();
        end
        bad = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (clk_out4 !== ck2) bad++;
            #2;
        end
        n_total++; if (bad != 0) $display("FAIL switch_clk_out_follow got=%0d mismatching samples exp=0", bad); else n_pass++;
    endtask

    task automatic test_same_sel();
        exp_t e;
        apply_reset();
        req4.req_valid = 1'b1;
        req4.req_sel   = 2'd0;
        sb.push_back('{1'b0, 2'd0, 1});
        @(negedge clk);
        req4.req_valid = 1'b0;
        n_total++; if (busy4 !== 1'b1 || clk_en4 !== 1'b1) $display("FAIL same_cyc1 got busy=%b en=%b exp busy=1 en=1", busy4, clk_en4); else n_pass++;
        if (done4) begin
            e = sb.pop_front();
            n_total++; if (err4 !== e.is_err || sel_out4 !== e.sel || e.cyc != 1) $display("FAIL same_done got err=%b sel=%0d exp err=%b sel=%0d", err4, sel_out4, e.is_err, e.sel); else n_pass++;
        end else begin
            n_total++; $display("FAIL same_done got done=%b exp=1 at cycle 1", done4);
            sb.delete();
        end
        @(negedge clk);
        n_total++; if (busy4 !== 1'b0 || clk_en4 !== 1'b1 || done4 !== 1'b0) $display("FAIL same_cyc2 got busy=%b en=%b done=%b exp 0 1 0", busy4, clk_en4, done4); else n_pass++;
    endtask

    task automatic test_err();
        exp_t e;
        req3.req_valid = 1'b1;
        req3.req_sel   = 2'd3;
        sb.push_back('{1'b1, 2'd0, 1});
        @(negedge clk);
        req3.req_valid = 1'b0;
        if (err3 || done3) begin
            e = sb.pop_front();
            n_total++; if (err3 !== e.is_err || done3 !== 1'b0 || e.cyc != 1) $display("FAIL err_pulse got err=%b done=%b exp err=%b done=0", err3, done3, e.is_err); else n_pass++;
        end else begin
            n_total++; $display("FAIL err_pulse got err=0 exp=1 at cycle 1");
            sb.delete();
        end
        n_total++; if (sel_out3 !== 2'd0 || clk_en3 !== 1'b1 || busy3 !== 1'b0) $display("FAIL err_state got sel=%0d en=%b busy=%b exp sel=0 en=1 busy=0", sel_out3, clk_en3, busy3); else n_pass++;
        @(negedge clk);
        n_total++; if (err3 !== 1'b0 || done3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL err_cyc2 got err=%b done=%b busy=%b exp 000", err3, done3, busy3); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        req4.req_valid = 1'b1;
        req4.req_sel   = 2'd1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) req4.req_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_total++; if (sel_out4 !== 2'd0 || clk_en4 !== 1'b1 || busy4 !== 1'b0 || req4.req_ready !== 1'b1) $display("FAIL midreset_state got sel=%0d en=%b busy=%b rdy=%b exp sel=0 en=1 busy=0 rdy=1", sel_out4, clk_en4, busy4, req4.req_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req4.req_valid = 1'b1;
        req4.req_sel   = 2'd1;
        sb.push_back('{1'b0, 2'd1, 10});
        got = 1'b0;
        for (int c = 1; c <= 14 && !got; c++) begin
            @(negedge clk);
            if (c == 1) req4.req_valid = 1'b0;
            if (done4 || err4) begin
                got = 1'b1;
                e = sb.pop_front();
                n_total++; if (c != e.cyc || err4 !== e.is_err || sel_out4 !== e.sel) $display("FAIL midreset_redo got cyc=%0d err=%b sel=%0d exp cyc=%0d err=%b sel=%0d", c, err4, sel_out4, e.cyc, e.is_err, e.sel); else n_pass++;
            end
        end
        if (!got) begin
            n_total++; $display("FAIL midreset_timeout got=no done exp=done at cycle 10");
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        req4.req_valid = 1'b1;
        req4.req_sel   = 2'd1;
        sb.push_back('{1'b0, 2'd1, 10});
        sb.push_back('{1'b0, 2'd3, 21});
        for (int c = 1; c <= 30 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (c == 1)  req4.req_sel   = 2'd3;
            if (c == 12) req4.req_valid = 1'b0;
            if (done4 || err4) begin
                e = sb.pop_front();
                n_total++; if (c != e.cyc || err4 !== e.is_err || sel_out4 !== e.sel) $display("FAIL b2b_done got cyc=%0d err=%b sel=%0d exp cyc=%0d err=%b sel=%0d", c, err4, sel_out4, e.cyc, e.is_err, e.sel); else n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_total++; $display("FAIL b2b_timeout got=%0d pending exp=0", sb.size());
            sb.delete();
        end
        req4.req_valid = 1'b0;
        @(negedge clk);
        n_total++; if (sel_out4 !== 2'd3 || clk_en4 !== 1'b1 || busy4 !== 1'b0) $display("FAIL b2b_final got sel=%0d en=%b busy=%b exp sel=3 en=1 busy=0", sel_out4, clk_en4, busy4); else n_pass++;
    endtask

    initial begin
        req4.req_valid = 1'b0;
        req4.req_sel   = 2'd0;
        req3.req_valid = 1'b0;
        req3.req_sel   = 2'd0;
        test_reset();
        test_switch();
        test_same_sel();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=time limit exp=bench completion");
        $fatal(1, "watchdog");
    end

endmodule
